// File: rtl/calc_port_responder.sv
// Two-operand command responder: add/sub/shift with per-class response latency.
// Define CALC_OVFL_CHECK_EN to report add carry-out / sub borrow as overflow.
module calc_port_responder #(
    parameter int unsigned ALU_LAT = 3,
    parameter int unsigned SHF_LAT = 5
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [3:0]  req_cmd_in,
    input  logic [31:0] req_data_in,
    output logic [1:0]  out_resp,
    output logic [31:0] out_data,
    output logic        busy
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
`ifdef CALC_OVFL_CHECK_EN
    localparam logic [1:0] RESP_OVF  = 2'd2;
`endif
    localparam logic [1:0] RESP_INV  = 2'd3;

    localparam logic [CNT_W-1:0] ALU_CNT = CNT_W'(ALU_LAT - 1);
    localparam logic [CNT_W-1:0] SHF_CNT = CNT_W'(SHF_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OP2,
        S_WAIT,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          cmd_q, cmd_d;
    logic [DATA_W-1:0]   op1_q, op1_d;
    logic [DATA_W-1:0]   op2_q, op2_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          resp_q, resp_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                busy_q, busy_d;

    logic [1:0]          res_resp;
    logic [DATA_W-1:0]   res_data;
`ifdef CALC_OVFL_CHECK_EN
    logic [DATA_W:0]     sum_ext;
`endif

    // Result of the captured operation, from registered operands only
    always_comb begin
        res_resp = RESP_OK;
        res_data = '0;
`ifdef CALC_OVFL_CHECK_EN
        sum_ext  = {1'b0, op1_q} + {1'b0, op2_q};
`endif
        case (cmd_q)
            CMD_ADD: begin
`ifdef CALC_OVFL_CHECK_EN
                if (sum_ext[DATA_W]) begin
                    res_resp = RESP_OVF;
                end else begin
                    res_data = sum_ext[DATA_W-1:0];
                end
`else
                res_data = op1_q + op2_q;
`endif
            end
            CMD_SUB: begin
`ifdef CALC_OVFL_CHECK_EN
                if (op1_q > op2_q) begin
                    res_resp = RESP_OVF;
                end else begin
                    res_data = op2_q - op1_q;
                end
`else
                res_data = op2_q - op1_q;
`endif
            end
            CMD_SHL: res_data = op1_q << op2_q[4:0];
            CMD_SHR: res_data = op1_q >> op2_q[4:0];
            default: res_resp = RESP_INV;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        cnt_d   = cnt_q;
        resp_d  = RESP_NONE;
        data_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (req_cmd_in != CMD_NOP) begin
                    cmd_d   = req_cmd_in;
                    op1_d   = req_data_in;
                    state_d = S_OP2;
                end
            end
            S_OP2: begin
                op2_d   = req_data_in;
                state_d = S_WAIT;
                case (cmd_q)
                    CMD_ADD, CMD_SUB: cnt_d = ALU_CNT;
                    CMD_SHL, CMD_SHR: cnt_d = SHF_CNT;
                    default:          cnt_d = '0;
                endcase
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    resp_d  = res_resp;
                    data_d  = res_data;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            cnt_q   <= '0;
            resp_q  <= RESP_NONE;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign out_resp = resp_q;
    assign out_data = data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_calc_port_responder.sv
// Scoreboard bench for calc_port_responder: directed cases plus randomized traffic
// against an arithmetic reference model; honours CALC_OVFL_CHECK_EN like the DUT.
module tb_calc_port_responder;

    localparam int unsigned ALU_LAT = 3;
    localparam int unsigned SHF_LAT = 5;

    logic        c_clk;
    logic        reset;
    logic [3:0]  req_cmd_in;
    logic [31:0] req_data_in;
    logic [1:0]  out_resp;
    logic [31:0] out_data;
    logic        busy;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        int          cyc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;

    calc_port_responder #(
        .ALU_LAT(ALU_LAT),
        .SHF_LAT(SHF_LAT)
    ) dut (
        .c_clk      (c_clk),
        .reset      (reset),
        .req_cmd_in (req_cmd_in),
        .req_data_in(req_data_in),
        .out_resp   (out_resp),
        .out_data   (out_data),
        .busy       (busy)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    always @(posedge c_clk) edge_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, expv, edge_cnt);
        end
    endtask

    // Reference: result code, data and latency straight from the command rules
    task automatic model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         output logic [1:0] r, output logic [31:0] d, output int lat);
        longint unsigned s;
        logic [4:0] sh;
        bit ovf;
        sh  = b[4:0];
        r   = 2'd1;
        d   = 32'd0;
        ovf = 1'b0;
        case (c)
            4'd1: begin
                s   = longint'(a) + longint'(b);
                d   = 32'(s);
                ovf = (s > 64'h0000_0000_FFFF_FFFF);
                lat = int'(ALU_LAT);
            end
            4'd2: begin
                d   = b - a;
                ovf = (a > b);
                lat = int'(ALU_LAT);
            end
            4'd5: begin d = a << sh; lat = int'(SHF_LAT); end
            4'd6: begin d = a >> sh; lat = int'(SHF_LAT); end
            default: begin r = 2'd3; lat = 1; end
        endcase
`ifdef CALC_OVFL_CHECK_EN
        if (ovf) begin
            r = 2'd2;
            d = 32'd0;
        end
`else
        ovf = 1'b0;
`endif
    endtask

    // Monitor: every non-idle response must match the oldest expectation
    always @(negedge c_clk) begin
        exp_t e;
        if (reset) begin
            if (out_resp != 2'd0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got resp %0d data 0x%0h expected no response (edge %0d)",
                             out_resp, out_data, edge_cnt);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_resp"}, 32'(out_resp), 32'(e.resp));
                    chk({e.name, "_data"}, out_data, e.data);
                    chk({e.name, "_edge"}, 32'(edge_cnt), 32'(e.cyc));
                    chk({e.name, "_busy"}, 32'(busy), 32'd1);
                end
            end else begin
                chk("idle_data_zero", out_data, 32'd0);
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge c_clk);
            req_cmd_in  = 4'd0;
            req_data_in = $urandom;
        end
    endtask

    // One transaction; commands thrown at the DUT while it is busy must be dropped
    task automatic do_txn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input string name);
        exp_t e;
        int   lat;
        @(negedge c_clk);
        chk({name, "_idle_busy"}, 32'(busy), 32'd0);
        req_cmd_in  = c;
        req_data_in = a;
        @(negedge c_clk);
        chk({name, "_op2_busy"}, 32'(busy), 32'd1);
        req_cmd_in  = 4'($urandom_range(1, 15));
        req_data_in = b;
        model(c, a, b, e.resp, e.data, lat);
        e.cyc  = edge_cnt + 1 + lat;
        e.name = name;
        exp_q.push_back(e);
        for (int i = 0; i <= lat; i++) begin
            @(negedge c_clk);
            req_cmd_in  = (i == 0) ? 4'd1 : 4'($urandom_range(0, 15));
            req_data_in = $urandom;
        end
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'hFFFF_FFFF;
            1: v = 32'h0000_0000;
            2: v = 32'h8000_0000;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] pick_cmd();
        logic [3:0] v;
        case ($urandom_range(0, 4))
            0: v = 4'd1;
            1: v = 4'd2;
            2: v = 4'd5;
            3: v = 4'd6;
            default: begin
                v = 4'($urandom_range(3, 15));
                if (v == 4'd5 || v == 4'd6) v = 4'd9;
            end
        endcase
        return v;
    endfunction

    initial begin
        int wait_cnt;
        reset       = 1'b0;
        req_cmd_in  = 4'd0;
        req_data_in = 32'd0;
        repeat (3) @(negedge c_clk);
        chk("rst_resp", 32'(out_resp), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;

        do_txn(4'd1, 32'h0000_0005, 32'h0000_0007, "add_5_7");
        do_txn(4'd1, 32'hFFFF_FFFF, 32'h0000_0001, "add_carry");
        do_txn(4'd2, 32'h0000_0010, 32'h0000_0008, "sub_borrow");
        do_txn(4'd2, 32'h0000_0008, 32'h0000_0010, "sub_ok");
        do_txn(4'd5, 32'h0000_0001, 32'h0000_0023, "shl_mask");
        do_txn(4'd6, 32'h8000_0000, 32'd31, "shr_31");
        do_txn(4'd9, 32'h1234_5678, 32'h9ABC_DEF0, "invalid_9");
        idle(2);

        // Asynchronous reset during WAIT of an add: operation must vanish
        @(negedge c_clk);
        req_cmd_in  = 4'd1;
        req_data_in = 32'd100;
        @(negedge c_clk);
        req_cmd_in  = 4'd0;
        req_data_in = 32'd200;
        @(negedge c_clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_resp", 32'(out_resp), 32'd0);
        chk("midrst_data", out_data, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge c_clk);
        @(negedge c_clk);
        reset = 1'b1;
        idle(ALU_LAT + 3);
        chk("postrst_busy", 32'(busy), 32'd0);
        do_txn(4'd1, 32'd2, 32'd3, "add_after_rst");

        for (int t = 0; t < 150; t++) begin
            do_txn(pick_cmd(), pick_operand(), pick_operand(), "rand");
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(2);

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 100) begin
            @(negedge c_clk);
            wait_cnt++;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_port_responder.md
CALC_PORT_RESPONDER -- requirements
Module: calc_port_responder

Interface
REQ-001 Parameter ALU_LAT, default 3: cycles from operand-2 capture to response for add/sub (legal 1-15).
REQ-002 Parameter SHF_LAT, default 5: cycles from operand-2 capture to response for shifts (legal 1-15).
REQ-003 c_clk  in  1  sole clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req_cmd_in  in  4  command: 0 no-op, 1 add, 2 sub, 5 shl, 6 shr; all others invalid.
REQ-006 req_data_in  in  32  operand 1 in the command cycle, operand 2 in the following cycle.
REQ-007 out_resp  out  2  0 none, 1 success, 2 overflow/underflow, 3 invalid command.
REQ-008 out_data  out  32  result, valid only while out_resp is 1.
REQ-009 busy  out  1  high from command capture through the response cycle.

Function
REQ-010 FSM states: IDLE, OP2, WAIT, RESP; reset state IDLE.
REQ-011 IDLE: nonzero req_cmd_in at an edge captures cmd and operand 1 -> OP2; cmd 0 stays IDLE.
REQ-012 OP2: next edge captures req_data_in as operand 2 unconditionally (req_cmd_in ignored); load latency counter with ALU_LAT-1 (cmd 1/2), SHF_LAT-1 (cmd 5/6), 0 (invalid) -> WAIT.
REQ-013 WAIT: counter decrements each edge; at 0 -> RESP.
REQ-014 Latency: operand 2 captured at edge N; response visible after edge N+ALU_LAT (add/sub), N+SHF_LAT (shift), N+1 (invalid).
REQ-015 RESP: out_resp/out_data hold exactly one cycle, then IDLE; a command present during RESP is ignored.
REQ-016 Outside RESP: out_resp = 0 and out_data = 0.
REQ-017 Commands presented while busy (OP2/WAIT/RESP) are dropped silently; no response is ever generated for them.
REQ-018 Add: 33-bit sum; out_data = low 32 bits.
REQ-019 Sub: out_data = operand2 - operand1 modulo 2^32; borrow when operand1 > operand2 (unsigned).
REQ-020 Shl/shr: shift operand 1 logically by operand2[4:0]; operand2[31:5] ignored; never overflows.
REQ-021 Invalid command: out_resp = 3, out_data = 0.
REQ-022 Result computed into a registered result register before RESP; no combinational path from inputs to outputs.

Reset
REQ-023 reset low forces IDLE, busy 0, out_resp 0, out_data 0, counter 0, captured operands/cmd 0 immediately, independent of c_clk.
REQ-024 Reset asserted mid-operation (OP2/WAIT/RESP) discards the operation; no response after release.
REQ-025 First command accepted at the first rising edge with reset high.

Configuration
REQ-026 Macro CALC_OVFL_CHECK_EN defined: add carry-out or sub borrow yields out_resp = 2, out_data = 0.
REQ-027 Macro CALC_OVFL_CHECK_EN undefined: add/sub always out_resp = 1 with the wrapped 32-bit result.

Verification
REQ-028 cmd 1, op1 0x0000_0005, op2 0x0000_0007 -> resp 1, data 0x0000_000C exactly ALU_LAT cycles after op2 edge, one cycle wide.
REQ-029 cmd 1, op1 0xFFFF_FFFF, op2 0x0000_0001 -> with CALC_OVFL_CHECK_EN resp 2 data 0; without, resp 1 data 0x0000_0000.
REQ-030 cmd 2, op1 0x10, op2 0x08 -> with macro resp 2; without, resp 1 data 0xFFFF_FFF8; cmd 2, op1 0x08, op2 0x10 -> resp 1 data 0x08.
REQ-031 cmd 5, op1 0x0000_0001, op2 0x0000_0023 -> resp 1, data 0x0000_0008 after SHF_LAT cycles; cmd 6, op1 0x8000_0000, op2 31 -> data 0x0000_0001.
REQ-032 cmd 9, any operands -> resp 3, data 0 one cycle after op2 edge; cmd 1 issued during WAIT -> dropped, only first response seen.
REQ-033 reset driven low between edges during WAIT of a cmd 1 -> outputs 0 immediately, no response after release; next cmd 1 (2+3) -> resp 1 data 5.
